// File: rtl/collision_scanner.sv
// Per-frame collision engine: scans one wall per clock against a bird box latched at start,
// adds a floor test, and debounces hit frames into a sticky game_over flag.
module collision_scanner #(
   parameter int                  COORD_W    = 8,
   parameter int                  NUM_WALLS  = 4,
   parameter int                  HIT_FRAMES = 1,
   parameter logic [COORD_W-1:0]  FLOOR_Y    = 8'd230,
   localparam int                 SEL_W      = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1,
   localparam int                 STREAK_W   = $clog2(HIT_FRAMES + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               clear,
   input  logic [COORD_W-1:0] bird_xleft,
   input  logic [COORD_W-1:0] bird_xright,
   input  logic [COORD_W-1:0] bird_ytop,
   input  logic [COORD_W-1:0] bird_ybottom,
   output logic [SEL_W-1:0]   wall_sel,
   input  logic [COORD_W-1:0] wall_xleft,
   input  logic [COORD_W-1:0] wall_xright,
   input  logic [COORD_W-1:0] wall_topy,
   input  logic [COORD_W-1:0] wall_bottomy,
   input  logic               wall_valid,
   output logic               busy,
   output logic               done,
   output logic               frame_hit,
   output logic               floor_hit,
   output logic [SEL_W-1:0]   hit_index,
   output logic               game_over
);

   // state | meaning
   // IDLE  | waiting for start; bird box not yet latched
   // SCAN  | evaluating wall[wall_sel], one wall per clock
   // DONE  | done pulse; frame results and streak already published
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [SEL_W-1:0]    LAST_SEL = SEL_W'(NUM_WALLS - 1);
   localparam logic [STREAK_W-1:0] HIT_MAX  = STREAK_W'(HIT_FRAMES);

   state_t              state;
   logic [COORD_W-1:0]  box_xleft, box_xright, box_ytop, box_ybottom;
   logic                any_hit, found;
   logic [SEL_W-1:0]    first_idx;
   logic [STREAK_W-1:0] streak;

   logic                wall_hit, floor_now, frame_any;
   logic [SEL_W-1:0]    idx_next;
   logic [STREAK_W-1:0] streak_next;

   always_comb begin
      wall_hit  = wall_valid
                  && (box_xright >= wall_xleft) && (box_xleft <= wall_xright)
                  && ((box_ytop <= wall_topy) || (box_ybottom >= wall_bottomy));
      floor_now = (box_ybottom >= FLOOR_Y);
      // the wall on the final scan cycle is folded in directly since its hit isn't registered yet
      frame_any = any_hit || wall_hit || floor_now;
      idx_next  = found ? first_idx : (wall_hit ? wall_sel : '0);
      if (!frame_any)
         streak_next = '0;
      else if (streak == HIT_MAX)
         streak_next = streak;
      else
         streak_next = streak + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wall_sel    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_hit   <= 1'b0;
         floor_hit   <= 1'b0;
         hit_index   <= '0;
         game_over   <= 1'b0;
         streak      <= '0;
         any_hit     <= 1'b0;
         found       <= 1'b0;
         first_idx   <= '0;
         box_xleft   <= '0;
         box_xright  <= '0;
         box_ytop    <= '0;
         box_ybottom <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  box_xleft   <= bird_xleft;
                  box_xright  <= bird_xright;
                  box_ytop    <= bird_ytop;
                  box_ybottom <= bird_ybottom;
                  wall_sel    <= '0;
                  any_hit     <= 1'b0;
                  found       <= 1'b0;
                  first_idx   <= '0;
                  busy        <= 1'b1;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               if (wall_hit) begin
                  any_hit <= 1'b1;
                  if (!found) begin
                     found     <= 1'b1;
                     first_idx <= wall_sel;
                  end
               end
               if (wall_sel == LAST_SEL) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  frame_hit <= frame_any;
                  floor_hit <= floor_now;
                  hit_index <= idx_next;
                  streak    <= streak_next;
                  if (streak_next == HIT_MAX)
                     game_over <= 1'b1;
               end else begin
                  wall_sel <= wall_sel + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // clear overrides any streak/game_over update made above in the same cycle
         if (clear) begin
            streak    <= '0;
            game_over <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_collision_scanner.sv
// Randomised and directed frames for collision_scanner, checked against a frame-level
// model of the hit rules and the hit-streak debounce.
module tb_collision_scanner;

   localparam int COORD_W    = 8;
   localparam int NUM_WALLS  = 4;
   localparam int HIT_FRAMES = 2;
   localparam int FLOOR      = 230;

   logic       clk = 1'b0;
   logic       reset, start, clear;
   logic [7:0] bird_xleft, bird_xright, bird_ytop, bird_ybottom;
   logic [1:0] wall_sel, hit_index;
   logic [7:0] wall_xleft, wall_xright, wall_topy, wall_bottomy;
   logic       wall_valid, busy, done, frame_hit, floor_hit, game_over;

   logic [7:0] wxl [NUM_WALLS];
   logic [7:0] wxr [NUM_WALLS];
   logic [7:0] wtop[NUM_WALLS];
   logic [7:0] wbot[NUM_WALLS];
   logic       wvld[NUM_WALLS];

   assign wall_xleft   = wxl[wall_sel];
   assign wall_xright  = wxr[wall_sel];
   assign wall_topy    = wtop[wall_sel];
   assign wall_bottomy = wbot[wall_sel];
   assign wall_valid   = wvld[wall_sel];

   collision_scanner #(
      .COORD_W(COORD_W), .NUM_WALLS(NUM_WALLS), .HIT_FRAMES(HIT_FRAMES), .FLOOR_Y(8'd230)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .bird_xleft(bird_xleft), .bird_xright(bird_xright),
      .bird_ytop(bird_ytop), .bird_ybottom(bird_ybottom),
      .wall_sel(wall_sel),
      .wall_xleft(wall_xleft), .wall_xright(wall_xright),
      .wall_topy(wall_topy), .wall_bottomy(wall_bottomy), .wall_valid(wall_valid),
      .busy(busy), .done(done), .frame_hit(frame_hit), .floor_hit(floor_hit),
      .hit_index(hit_index), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int m_streak = 0;
   int m_go     = 0;
   int exp_fh, exp_fl, exp_idx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_bird(input int xl, input int xr, input int yt, input int yb);
      bird_xleft   = 8'(xl);
      bird_xright  = 8'(xr);
      bird_ytop    = 8'(yt);
      bird_ybottom = 8'(yb);
   endtask

   task automatic set_walls(input int xl, input int xr, input int top, input int bot, input logic v);
      for (int i = 0; i < NUM_WALLS; i++) begin
         wxl[i] = 8'(xl); wxr[i] = 8'(xr); wtop[i] = 8'(top); wbot[i] = 8'(bot); wvld[i] = v;
      end
   endtask

   task automatic model_frame(input int xl, input int xr, input int yt, input int yb);
      bit found = 0;
      exp_idx = 0;
      for (int i = 0; i < NUM_WALLS; i++) begin
         if (wvld[i] && xr >= int'(wxl[i]) && xl <= int'(wxr[i])
             && (yt <= int'(wtop[i]) || yb >= int'(wbot[i]))) begin
            if (!found) exp_idx = i;
            found = 1;
         end
      end
      exp_fl = (yb >= FLOOR) ? 1 : 0;
      exp_fh = (found || exp_fl) ? 1 : 0;
   endtask

   // mode 0: plain frame, 1: clear coincides with the DONE update, 2: extra start during SCAN
   task automatic run_frame(input string name, input int mode);
      int n = 0;
      int extra = 0;
      bit got = 0;
      model_frame(bird_xleft, bird_xright, bird_ytop, bird_ybottom);
      if (mode == 1) begin
         m_streak = 0; m_go = 0;
      end else if (exp_fh) begin
         m_streak = (m_streak < HIT_FRAMES) ? m_streak + 1 : HIT_FRAMES;
         if (m_streak == HIT_FRAMES) m_go = 1;
      end else begin
         m_streak = 0;
      end
      @(negedge clk); start = 1'b1;
      while (n < 20 && !got) begin
         @(negedge clk); n++;
         start = (mode == 2 && n == 2);
         clear = (mode == 1 && n == 4);
         if (n == 1) set_bird($urandom_range(0, 255), $urandom_range(0, 255),
                              $urandom_range(0, 255), $urandom_range(0, 255));
         if (done) got = 1;
      end
      start = 1'b0; clear = 1'b0;
      check({name, " latency"},   n,          5);
      check({name, " busy"},      busy,       1);
      check({name, " frame_hit"}, frame_hit,  exp_fh);
      check({name, " floor_hit"}, floor_hit,  exp_fl);
      check({name, " hit_index"}, hit_index,  exp_idx);
      check({name, " game_over"}, game_over,  m_go);
      @(negedge clk);
      check({name, " done_pulse"}, {busy, done}, 0);
      check({name, " held"},       frame_hit,    exp_fh);
      if (mode == 2) begin
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) extra++;
         end
         check({name, " extra_done"}, extra, 0);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, " wall_sel"},  wall_sel,  0);
      check({name, " busy"},      busy,      0);
      check({name, " done"},      done,      0);
      check({name, " frame_hit"}, frame_hit, 0);
      check({name, " floor_hit"}, floor_hit, 0);
      check({name, " hit_index"}, hit_index, 0);
      check({name, " game_over"}, game_over, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int extra;
      reset = 1'b1; start = 1'b0; clear = 1'b0;
      set_bird(20, 28, 100, 108);
      set_walls(60, 70, 80, 130, 1'b1);
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;

      run_frame("clean", 0);

      set_bird(20, 28, 100, 108);
      wvld[1] = 1; wxl[1] = 25; wxr[1] = 35; wtop[1] = 110; wbot[1] = 150;
      wvld[3] = 1; wxl[3] = 25; wxr[3] = 35; wtop[3] = 110; wbot[3] = 150;
      run_frame("multi", 0);
      set_bird(10, 25, 100, 108);
      run_frame("edge_x", 0);

      set_walls(60, 70, 80, 130, 1'b1);
      set_bird(20, 28, 100, 108);
      run_frame("sticky", 0);

      set_walls(25, 35, 110, 150, 1'b1);
      set_bird(20, 28, 100, 108);
      run_frame("clear_done", 1);

      run_frame("hcH_1", 0);
      set_walls(60, 70, 80, 130, 1'b1);
      set_bird(20, 28, 100, 108);
      run_frame("hcH_2", 0);
      set_walls(25, 35, 110, 150, 1'b1);
      set_bird(20, 28, 100, 108);
      run_frame("hcH_3", 0);

      set_walls(25, 35, 110, 150, 1'b0);
      set_bird(20, 28, 220, 230);
      run_frame("floor", 0);

      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < NUM_WALLS; i++) begin
            wxl[i]  = 8'($urandom_range(0, 200));
            wxr[i]  = wxl[i] + 8'($urandom_range(0, 50));
            wtop[i] = 8'($urandom_range(0, 150));
            wbot[i] = wtop[i] + 8'($urandom_range(1, 100));
            wvld[i] = ($urandom_range(0, 3) != 0);
         end
         n = $urandom_range(0, 200);
         extra = $urandom_range(0, 200);
         set_bird(n, n + $urandom_range(0, 50), extra, extra + $urandom_range(0, 55));
         run_frame($sformatf("rand%0d", f), 0);
      end

      set_walls(60, 70, 80, 130, 1'b1);
      set_bird(20, 28, 100, 108);
      run_frame("restart", 2);

      set_walls(25, 35, 110, 150, 1'b1);
      set_bird(20, 28, 100, 108);
      run_frame("pre_rst1", 0);
      set_bird(20, 28, 100, 108);
      run_frame("pre_rst2", 0);
      set_bird(20, 28, 100, 108);
      @(negedge clk); start = 1'b1;
      n = 0;
      while (n < 20 && wall_sel != 2'd2) begin
         @(negedge clk); n++;
         start = 1'b0;
      end
      check("rst_reach_sel2", n, 3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_streak = 0; m_go = 0;
      check_idle_outputs("midscan_reset");
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("rst_no_done", extra, 0);

      set_walls(25, 35, 110, 150, 1'b1);
      set_bird(20, 28, 100, 108);
      run_frame("post_rst", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
